// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared definitions for the register-file writeback scoreboard.
// Optional same-cycle release is enabled with RF_SB_BYPASS_EN.
package rf_wb_scoreboard_pkg;

  localparam int RegBus = 32;
  localparam int RegNum = 32;
  localparam int Reg0   = 0;
  localparam logic [RegBus-1:0] RST_VAL = '0;

  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic {
    WB_LSU_PRI   = 1'b0,
    WB_ALU_FORCE = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/rf_wb_arb.sv
// Two-source writeback arbiter: LSU normally wins, but the ALU is forced
// a grant after STARVE_MAX consecutive LSU grants while it was waiting.
module rf_wb_arb
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_arb_state_e state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    alu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      WB_LSU_PRI: begin
        lsu_gnt = lsu_valid;
        alu_gnt = alu_valid && !lsu_valid;
        // Only LSU wins that actually kept a waiting ALU out count as starvation.
        if (lsu_gnt && alu_valid) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(STARVE_MAX - 1))
            state_next = WB_ALU_FORCE;
        end else begin
          cnt_next = '0;
        end
      end
      default: begin
        alu_gnt    = alu_valid;
        lsu_gnt    = lsu_valid && !alu_valid;
        state_next = WB_LSU_PRI;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WB_LSU_PRI;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file scoreboard: busy bits, RAW/WAW issue check and the
// registered register-file write port. Define RF_SB_BYPASS_EN for same-cycle release.
module rf_wb_scoreboard
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int XLEN       = RegBus,
  parameter int NUM_REGS   = RegNum,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iss_valid,
  output logic                        iss_ready,
  input  logic [$clog2(NUM_REGS)-1:0] iss_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] iss_rs2,
  input  logic [$clog2(NUM_REGS)-1:0] iss_rd,
  input  logic                        iss_rd_we,
  input  logic                        alu_wb_valid,
  output logic                        alu_wb_ready,
  input  logic [$clog2(NUM_REGS)-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]             alu_wb_data,
  input  logic                        lsu_wb_valid,
  output logic                        lsu_wb_ready,
  input  logic [$clog2(NUM_REGS)-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]             lsu_wb_data,
  output logic                        rf_wen,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd,
  output logic [XLEN-1:0]             rf_result,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic                        wb_err
);

  localparam int IW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy_reg, busy_next, busy_eff, clr_mask, set_mask;
  logic                alu_gnt, lsu_gnt, wb_gnt, wb_live, iss_fire;
  logic [IW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                rf_wen_reg, wb_err_reg;
  logic [IW-1:0]       rf_rd_reg;
  logic [XLEN-1:0]     rf_result_reg;

  rf_wb_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_wb_valid),
    .lsu_valid (lsu_wb_valid),
    .alu_gnt   (alu_gnt),
    .lsu_gnt   (lsu_gnt)
  );

  assign alu_wb_ready = alu_gnt;
  assign lsu_wb_ready = lsu_gnt;
  assign wb_gnt       = alu_gnt || lsu_gnt;
  assign wb_rd        = alu_gnt ? alu_wb_rd : lsu_wb_rd;
  assign wb_data      = alu_gnt ? alu_wb_data : lsu_wb_data;
  // Writebacks to register 0 are accepted but have no architectural effect.
  assign wb_live      = wb_gnt && (wb_rd != IW'(Reg0));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign clr_mask[gi]  = 1'b0;
        assign set_mask[gi]  = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign clr_mask[gi]  = wb_live && (wb_rd == IW'(gi));
        assign set_mask[gi]  = iss_fire && iss_rd_we && (iss_rd == IW'(gi));
        // Set wins over a same-cycle clear of the same register.
        assign busy_next[gi] = set_mask[gi] || (busy_reg[gi] && !clr_mask[gi]);
      end
    end
  endgenerate

`ifdef RF_SB_BYPASS_EN
  assign busy_eff = busy_reg & ~clr_mask;
`else
  assign busy_eff = busy_reg;
`endif

  assign iss_ready = !busy_eff[iss_rs1] && !busy_eff[iss_rs2] &&
                     !(iss_rd_we && busy_eff[iss_rd]);
  assign iss_fire  = iss_valid && iss_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg      <= '0;
      rf_wen_reg    <= 1'b0;
      rf_rd_reg     <= '0;
      rf_result_reg <= XLEN'(RST_VAL);
      wb_err_reg    <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      rf_wen_reg <= wb_live;
      if (wb_gnt) begin
        rf_rd_reg     <= wb_rd;
        rf_result_reg <= wb_data;
      end
      if (wb_live && !busy_reg[wb_rd])
        wb_err_reg <= 1'b1;
    end
  end

  assign rf_wen    = rf_wen_reg;
  assign rf_rd     = rf_rd_reg;
  assign rf_result = rf_result_reg;
  assign busy_vec  = busy_reg;
  assign wb_err    = wb_err_reg;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Randomized and directed bench for rf_wb_scoreboard against a behavioural model.
// Honours RF_SB_BYPASS_EN the same way the design does.
module tb_rf_wb_scoreboard;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 0, iss_ready, iss_rd_we = 0;
  logic [4:0]  iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0;
  logic        alu_wb_valid = 0, alu_wb_ready, lsu_wb_valid = 0, lsu_wb_ready;
  logic [4:0]  alu_wb_rd = 0, lsu_wb_rd = 0, rf_rd;
  logic [31:0] alu_wb_data = 0, lsu_wb_data = 0, rf_result, busy_vec;
  logic        rf_wen, wb_err;

  rf_wb_scoreboard #(.XLEN(32), .NUM_REGS(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_result(rf_result),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: set of busy registers, LSU streak length, write port.
  bit [31:0]   m_busy;
  int          m_streak;
  bit          m_wen, m_err;
  bit [4:0]    m_rd;
  bit [31:0]   m_res;
  bit          obs_ready, obs_alu_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_streak = 0; m_wen = 0; m_err = 0; m_rd = 0; m_res = 0;
  endtask

  task automatic drive(input bit iv, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit we,
                       input bit av, input bit [4:0] ard, input bit [31:0] ad,
                       input bit lv, input bit [4:0] lrd, input bit [31:0] ld);
    iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_we = we;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
  endtask

  // One cycle: inputs already driven after a negedge; check combinational
  // outputs, advance the model, clock, then check the registered outputs.
  task automatic cyc();
    bit force_alu, ag, lg, g, exp_ready, fire;
    bit [4:0] wrd;
    bit [31:0] wd, clr, eff, setm;
    #1;
    force_alu = (m_streak >= SMAX);
    if (force_alu) begin
      ag = alu_wb_valid; lg = lsu_wb_valid && !alu_wb_valid;
    end else begin
      lg = lsu_wb_valid; ag = alu_wb_valid && !lsu_wb_valid;
    end
    g   = ag || lg;
    wrd = ag ? alu_wb_rd : lsu_wb_rd;
    wd  = ag ? alu_wb_data : lsu_wb_data;
    clr = (g && wrd != 0) ? (32'd1 << wrd) : 32'd0;
`ifdef RF_SB_BYPASS_EN
    eff = m_busy & ~clr;
`else
    eff = m_busy;
`endif
    exp_ready = !eff[iss_rs1] && !eff[iss_rs2] && !(iss_rd_we && eff[iss_rd]);
    chk("iss_ready", iss_ready, exp_ready);
    chk("alu_gnt", alu_wb_ready, ag);
    chk("lsu_gnt", lsu_wb_ready, lg);
    obs_ready = iss_ready;
    obs_alu_g = alu_wb_ready;
    fire = iss_valid && exp_ready;
    setm = (fire && iss_rd_we && iss_rd != 0) ? (32'd1 << iss_rd) : 32'd0;
    if (g && wrd != 0 && !m_busy[wrd]) m_err = 1;
    m_busy = (m_busy & ~clr) | setm;
    m_wen  = g && wrd != 0;
    if (g) begin m_rd = wrd; m_res = wd; end
    if (force_alu) m_streak = 0;
    else if (lg && alu_wb_valid) m_streak++;
    else m_streak = 0;
    @(posedge clk); #1;
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_result", rf_result, m_res);
    chk("busy_vec", busy_vec, m_busy);
    chk("wb_err", wb_err, m_err);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0,0,0,0,0, 0,0,0, 0,0,0);
    cyc();
  endtask

  bit [5:0] alu_pat;
  bit [4:0] r;

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_wen", rf_wen, 1'b0);
    chk("rst_err", wb_err, 1'b0);
    rst = 1'b0;

    // Reset while a write to r5 is in flight.
    drive(1,0,0,5,1, 0,0,0, 0,0,0); cyc();
    chk("busy5_set", busy_vec[5], 1'b1);
    #2 rst = 1'b1; #1;
    chk("midrst_busy", busy_vec, 32'd0);
    chk("midrst_wen", rf_wen, 1'b0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    drive(1,5,0,0,0, 0,0,0, 0,0,0); cyc();
    chk("midrst_ready", obs_ready, 1'b1);

    // RAW stall on r3 released by an LSU writeback.
    drive(1,0,0,3,1, 0,0,0, 0,0,0); cyc();
    drive(1,3,0,0,0, 0,0,0, 0,0,0); cyc();
    chk("raw_stall", obs_ready, 1'b0);
    drive(1,3,0,0,0, 0,0,0, 1,3,32'h1234_5678); cyc();
`ifdef RF_SB_BYPASS_EN
    chk("raw_grant_cycle", obs_ready, 1'b1);
`else
    chk("raw_grant_cycle", obs_ready, 1'b0);
    drive(1,3,0,0,0, 0,0,0, 0,0,0); cyc();
    chk("raw_after_grant", obs_ready, 1'b1);
`endif

    // Both sources valid back to back: four LSU grants, then ALU, then LSU.
    idle();
    for (int i = 0; i < 6; i++) begin
      drive(0,0,0,0,0, 1,5'(10+i),32'hA000_0000+i, 1,5'(20+i),32'hB000_0000+i);
      cyc();
      alu_pat[i] = obs_alu_g;
    end
    chk("starve_pattern", alu_pat, 6'b010000);

    // rd=0 writeback is absorbed silently; then clean up wb_err for the next test.
    rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
    drive(0,0,0,0,0, 1,0,32'hDEAD_BEEF, 0,0,0); cyc();
    chk("rd0_ready", obs_alu_g, 1'b1);
    chk("rd0_wen", rf_wen, 1'b0);
    chk("rd0_err", wb_err, 1'b0);

    // Writeback to a non-busy register sets a sticky error.
    drive(0,0,0,0,0, 1,7,32'h0000_0777, 0,0,0); cyc();
    chk("err_wen", rf_wen, 1'b1);
    chk("err_rd", rf_rd, 5'd7);
    chk("err_set", wb_err, 1'b1);
    idle(); idle();
    chk("err_sticky", wb_err, 1'b1);

    // WAW stall on r9, and the same instruction without a write issues.
    drive(1,0,0,9,1, 0,0,0, 0,0,0); cyc();
    drive(1,1,2,9,1, 0,0,0, 0,0,0); cyc();
    chk("waw_stall", obs_ready, 1'b0);
    drive(1,1,2,9,0, 0,0,0, 0,0,0); cyc();
    chk("waw_nowrite", obs_ready, 1'b1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0,1) == 1, 5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
            5'($urandom_range(0,7)), $urandom_range(0,3) != 0,
            0, 5'($urandom_range(0,7)), $urandom,
            0, 5'($urandom_range(0,7)), $urandom);
      r = alu_wb_rd;
      alu_wb_valid = m_busy[r] ? ($urandom_range(0,2) != 0) : ($urandom_range(0,9) == 0);
      r = lsu_wb_rd;
      lsu_wb_valid = m_busy[r] ? ($urandom_range(0,2) != 0) : ($urandom_range(0,9) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Controller for the 32-entry integer register file.
- Tracks registers with writes in flight (busy bits) and stalls issue on RAW/WAW hazards.
- Arbitrates the two writeback sources (ALU, LSU) onto the single register-file write port.
- Sits between decode/issue and the register file; its registered write-port outputs drive the register file's wen, rd and result inputs directly.

Parameters:
- XLEN, 32, data width of writeback result.
- NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS).
- STARVE_MAX, 4, consecutive LSU grants allowed while ALU waits before ALU is forced a grant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- iss_valid  in  1  decode presents an instruction.
- iss_ready  out  1  instruction may issue this cycle.
- iss_rs1, iss_rs2, iss_rd  in  5 each  source/destination indices.
- iss_rd_we  in  1  instruction writes rd.
- alu_wb_valid  in  1  ALU result pending.
- alu_wb_ready  out  1  ALU result accepted.
- alu_wb_rd  in  5  ALU destination.
- alu_wb_data  in  XLEN  ALU result.
- lsu_wb_valid, lsu_wb_ready, lsu_wb_rd, lsu_wb_data  in/out/in/in  1/1/5/XLEN  same handshake for LSU.
- rf_wen  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_result  out  XLEN  register-file write data.
- busy_vec  out  NUM_REGS  current busy bits; bit 0 always 0.
- wb_err  out  1  sticky: writeback to a non-busy nonzero register.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - busy_vec = 0, rf_wen = 0, rf_rd = 0, rf_result = 0.
  - Starve counter = 0, wb_err = 0, arbiter state = LSU_PRI.
  - In-flight writebacks are dropped.
- Issue:
  - iss_ready = !busy[rs1] && !busy[rs2] && !(iss_rd_we && busy[rd]), using registered busy only.
  - iss_ready is independent of iss_valid.
  - Issue fires when iss_valid && iss_ready.
  - On fire with iss_rd_we=1 and rd != 0: busy[rd] is set at the next edge.
  - Index 0 is never busy, so an rs or rd of 0 never stalls.
- Writeback handshake:
  - A source's data is consumed when valid && ready.
  - At most one grant per cycle.
  - Grant is combinational from the valids and the arbiter state.
- Arbiter FSM, two states:
  - LSU_PRI: LSU wins if valid, else ALU. Counter increments on each LSU grant while alu_wb_valid=1, and resets to 0 on any ALU grant or when ALU is idle. When the counter reaches STARVE_MAX → ALU_FORCE.
  - ALU_FORCE: ALU wins if valid, else LSU. After one ALU grant (or ALU not valid) → LSU_PRI, counter = 0.
- Commit (granted source):
  - Next edge: rf_wen=1, rf_rd=wb_rd, rf_result=wb_data. The outputs are registered, so the register file writes at the end of the following cycle (grant-to-RF-write latency 2 edges).
  - Same grant edge: busy[wb_rd] cleared.
  - No grant: rf_wen=0; rf_rd/rf_result hold.
- rd=0 writeback: accepted, rf_wen stays 0, busy unchanged, wb_err unchanged.
- Writeback to a nonzero register whose busy bit is 0: still written; wb_err set and held until reset.
- Same-cycle set (issue) and clear (commit) of the same index: set wins. Without the bypass feature this is unreachable, because WAW stalls.
- No fairness requirement beyond STARVE_MAX; the LSU may be held off for at most one grant.

Optional Feature:
- Macro RF_SB_BYPASS_EN.
- Defined:
  - A register being cleared by this cycle's grant is treated as not busy in the iss_ready computation (same-cycle release).
  - If the issuing instruction also writes that register, busy stays set (set wins).
  - Adds a combinational path from the wb valids to iss_ready.
- Undefined: iss_ready uses registered busy only, giving a one-cycle issue bubble after a commit.

Decomposition:
- Shared defines header holds the following already-existing defines, reused: RegBus, RegNum, Reg0, RST_VAL.
- Add to the same header:
  - arbiter state encodings WB_LSU_PRI=1'b0 and WB_ALU_FORCE=1'b1;
  - default STARVE_MAX.
- One sub-module: rf_wb_arb, containing the two-source arbiter FSM, starve counter and grant logic.
- Busy-bit array and issue check stay in the top module.

Test Plan:
- Reset mid-flight: issue rd=5, assert rst before its writeback → busy_vec=0, rf_wen=0, iss_ready=1 for rs1=5.
- RAW stall: issue rd=3 (long op), next issue rs1=3 → iss_ready=0 until LSU wb rd=3 granted.
  - Without bypass: ready 1 cycle after grant.
  - With RF_SB_BYPASS_EN: ready in the grant cycle.
- Both valid continuously, ALU waiting: grants LSU,LSU,LSU,LSU,ALU,LSU… (STARVE_MAX=4); each grant gives rf_wen=1 one edge later with matching rd/data.
- rd=0 writeback with data 0xDEADBEEF: ready=1, rf_wen=0, wb_err=0.
- ALU wb rd=7 with busy[7]=0: rf_wen=1, rf_rd=7, wb_err=1 and it stays 1 across later cycles.
- WAW: rd=9 busy, issue with rd=9 and iss_rd_we=1 → iss_ready=0.
  - Same instruction with iss_rd_we=0 and sources not busy → iss_ready=1.
